// File: rtl/div_arbiter.sv
// div_arbiter
// Round-robin scheduler that time-shares one registered signed divider among
// NREQ requesters. A winner's operands are latched in IDLE, the divider is
// clocked for exactly one cycle in ISSUE, and its result is captured at the
// end of WAIT and returned with a one-cycle DONE pulse to the winner.
//
// Optional feature macro: DIV_ZERO_CHECK_EN
//   defined   : a zero divisor never reaches the divider; the result is
//               QUOT_OUT = 0, REM_OUT = dividend, DZ_ERR = 1 with the same latency.
//   undefined : every operation goes to the divider, DZ_ERR is tied low.
//
// Ports
//   CLK, NRST    clock (rising edge), asynchronous active-low reset
//   REQ          per-requester request level
//   DIVIDEND_IN  packed signed dividends, requester i at [i*WIDTH +: WIDTH]
//   DIVISOR_IN   packed signed divisors, same packing
//   ACK          one-hot pulse: operands of that requester captured
//   DONE         one-hot pulse: QUOT_OUT/REM_OUT/DZ_ERR valid for that requester
//   QUOT_OUT     signed quotient, held until the next DONE
//   REM_OUT      signed remainder, held until the next DONE
//   DZ_ERR       divide-by-zero flag, valid with DONE
//   DIV_SCLR     divider synchronous clear, follows ~NRST
//   DIV_CE       divider clock enable, high for the ISSUE cycle only
//   DIV_A/DIV_B  divider dividend/divisor, always the latched operands
//   DIV_Q/DIV_R  divider quotient/remainder, valid in WAIT

module div_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  NRST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] DIVIDEND_IN,
  input  logic [NREQ*WIDTH-1:0] DIVISOR_IN,
  output logic [NREQ-1:0]       ACK,
  output logic [NREQ-1:0]       DONE,
  output logic [WIDTH-1:0]      QUOT_OUT,
  output logic [WIDTH-1:0]      REM_OUT,
  output logic                  DZ_ERR,
  output logic                  DIV_SCLR,
  output logic                  DIV_CE,
  output logic [WIDTH-1:0]      DIV_A,
  output logic [WIDTH-1:0]      DIV_B,
  input  logic [WIDTH-1:0]      DIV_Q,
  input  logic [WIDTH-1:0]      DIV_R
);

  localparam int IW = $clog2(NREQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t           state, next_state;
  logic [IW-1:0]    ptr;          // last granted requester (lowest priority)
  logic [IW-1:0]    win;          // requester owning the current operation
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    cand;
  logic             grant_valid;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [WIDTH-1:0] opa, opb;

  // ---------------------------------------------------------------------------
  // Round-robin pick: scan from the farthest candidate back to ptr+1 so the
  // nearest requested index after ptr is the last one written and wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant_valid = 1'b0;
    grant_idx   = ptr;
    cand        = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (REQ[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel_a = DIVIDEND_IN[grant_idx*WIDTH +: WIDTH];
    sel_b = DIVISOR_IN[grant_idx*WIDTH +: WIDTH];
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge NRST) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!NRST) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_valid) next_state = ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath. An asserted reset drops any in-flight operation: WAIT is left
  // before it can raise DONE.
  // ---------------------------------------------------------------------------
`ifdef DIV_ZERO_CHECK_EN
  logic zero_div;
  logic dz_q;
`endif

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      // NOTE: the operand and result registers are ordinary flops, not a
      // memory, so they take the reset and read as zero after reset.
      ptr      <= LAST_IDX;
      win      <= '0;
      opa      <= '0;
      opb      <= '0;
      ACK      <= '0;
      DONE     <= '0;
      DIV_CE   <= 1'b0;
      QUOT_OUT <= '0;
      REM_OUT  <= '0;
`ifdef DIV_ZERO_CHECK_EN
      zero_div <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      ACK    <= '0;
      DONE   <= '0;
      DIV_CE <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            opa <= sel_a;
            opb <= sel_b;
            win <= grant_idx;
            ptr <= grant_idx;
            ACK <= NREQ'(1) << grant_idx;
`ifdef DIV_ZERO_CHECK_EN
            zero_div <= (sel_b == '0);
            DIV_CE   <= (sel_b != '0);
`else
            DIV_CE   <= 1'b1;
`endif
          end
        end
        WAIT: begin
          DONE <= NREQ'(1) << win;
`ifdef DIV_ZERO_CHECK_EN
          if (zero_div) begin
            QUOT_OUT <= '0;
            REM_OUT  <= opa;
            dz_q     <= 1'b1;
          end else begin
            QUOT_OUT <= DIV_Q;
            REM_OUT  <= DIV_R;
            dz_q     <= 1'b0;
          end
`else
          QUOT_OUT <= DIV_Q;
          REM_OUT  <= DIV_R;
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  assign DZ_ERR = dz_q;
`else
  assign DZ_ERR = 1'b0;
`endif

  assign DIV_SCLR = ~NRST;
  assign DIV_A    = opa;
  assign DIV_B    = opb;

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin scheduler that shares one registered signed DIVIDER instance among NREQ requesters. It drives the divider's operand, CE and SCLR inputs, captures its QUOTIENT/FRACTIONAL outputs, and returns the result to the granted requester with a one-cycle DONE pulse. It sits between the keyboard-controller arithmetic clients and the single divider datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 32, operand/result width; must match the divider
- CLK  in  1  clock, rising edge
- NRST  in  1  asynchronous active-low reset
- REQ  in  NREQ  per-requester request level
- DIVIDEND_IN  in  NREQ*WIDTH  signed dividends, requester i at [i*WIDTH +: WIDTH]
- DIVISOR_IN  in  NREQ*WIDTH  signed divisors, same packing
- ACK  out  NREQ  one-hot, 1-cycle pulse: operands of that requester captured
- DONE  out  NREQ  one-hot, 1-cycle pulse: QUOT_OUT/REM_OUT valid for that requester
- QUOT_OUT  out  WIDTH  signed quotient
- REM_OUT  out  WIDTH  signed remainder
- DZ_ERR  out  1  divide-by-zero flag, valid with DONE
- DIV_SCLR  out  1  to divider SCLR; equals ~NRST
- DIV_CE  out  1  to divider CE
- DIV_A  out  WIDTH  to divider DEVIDENT
- DIV_B  out  WIDTH  to divider DIVISOR
- DIV_Q  in  WIDTH  from divider QUOTIENT
- DIV_R  in  WIDTH  from divider FRACTIONAL

## Operation
- States: IDLE, ISSUE, WAIT. Reset state IDLE.
- IDLE: if any REQ bit set, pick winner = first set bit searching upward from (PTR+1) mod NREQ; latch its dividend/divisor into OPA/OPB, latch winner index, ACK <= onehot(winner), PTR <= winner, go ISSUE. No REQ: stay IDLE.
- ISSUE: DIV_CE = 1 (registered, high for exactly this cycle), DIV_A = OPA, DIV_B = OPB; go WAIT.
- WAIT: DIV_Q/DIV_R valid; at end of cycle QUOT_OUT <= DIV_Q, REM_OUT <= DIV_R, DONE <= onehot(winner), go IDLE.
- DIV_A/DIV_B hold OPA/OPB in all states (no toggling outside ISSUE is required of the divider).
- Arithmetic: signed, truncation toward zero, remainder takes dividend's sign (divider semantics). -2^(WIDTH-1) / -1 returns whatever divider returns (quotient wraps to -2^(WIDTH-1), remainder 0); no flag.
- Requester rule: hold REQ and operands stable until ACK; REQ still high in the next IDLE after ACK is a new request.
- Fairness: PTR resets to NREQ-1, so requester 0 wins first; granted requester becomes lowest priority.
- Requests arriving in ISSUE/WAIT are ignored until IDLE; no queueing beyond REQ level.
- Reset (any time, incl. mid-operation): state IDLE, PTR = NREQ-1, ACK = DONE = 0, QUOT_OUT = REM_OUT = 0, DZ_ERR = 0, DIV_CE = 0, OPA = OPB = 0, DIV_SCLR = 1 while NRST low. In-flight operation is dropped without DONE.

## Timing
- Cycle 0: REQ sampled in IDLE. Cycle 1: ACK high, DIV_CE high. Cycle 2: WAIT. Cycle 3: DONE high, results valid, state IDLE.
- Latency REQ-to-DONE: 3 cycles. Max throughput: one operation per 3 cycles (new grant decided in the DONE cycle).
- QUOT_OUT/REM_OUT/DZ_ERR hold until the next DONE.

## Configuration
- DIV_ZERO_CHECK_EN defined: in IDLE, a latched divisor of 0 sets a zero flag; ISSUE keeps DIV_CE = 0; at end of WAIT QUOT_OUT <= 0, REM_OUT <= OPA, DZ_ERR <= 1, DONE as normal (latency unchanged). DZ_ERR <= 0 on every non-zero-divisor DONE.
- Undefined: no check; operation issued to divider, results are divider's (undefined for zero divisor); DZ_ERR tied 0.

## Test plan
- Single request: REQ[0]=1, 100/7 -> ACK[0] at cycle 1, DONE[0] at cycle 3, QUOT_OUT=14, REM_OUT=2.
- Signed: REQ[2], -100/7 -> QUOT_OUT=-14, REM_OUT=-2; 100/-7 -> 14 negated = -14, REM_OUT=2.
- Round-robin: REQ=4'b1111 held, each dropped after its ACK -> grants in order 0,1,2,3, DONE spaced 3 cycles apart.
- Fairness under contention: REQ[0] and REQ[1] held permanently -> grants alternate 0,1,0,1.
- Divide by zero with DIV_ZERO_CHECK_EN: 55/0 -> DIV_CE never high, DONE at cycle 3, QUOT_OUT=0, REM_OUT=55, DZ_ERR=1; following 9/3 -> 3, 0, DZ_ERR=0.
- Reset mid-op: NRST low during WAIT -> no DONE, all outputs 0, DIV_SCLR=1; after release REQ[3] wins only if requester 0..2 idle (PTR=NREQ-1).
